// File: rtl/sampler_dma_register_bank_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : sampler_dma_register_bank_if
// Purpose  : Register-bus bundle between the AXI-Lite slave and the DMA bank.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface sampler_dma_register_bank_if #(
    parameter int ADDR_W = 8
);
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic [ADDR_W-1:0] reg_addr_wr;
    logic [ADDR_W-1:0] reg_addr_rd;
    logic              data_wren;
    logic [3:0]        byte_enable;

    modport master (
        output data_in, reg_addr_wr, reg_addr_rd, data_wren, byte_enable,
        input  data_out
    );

    modport slave (
        input  data_in, reg_addr_wr, reg_addr_rd, data_wren, byte_enable,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/sampler_dma_register_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : sampler_dma_register_bank
// Purpose  : Per-voice DMA register file with shadowed base/length and IRQs.
// Revision : 1.0
// ----------------------------------------------------------------------------
module sampler_dma_register_bank #(
    parameter int          MAX_VOICES = 8,
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] VERSION_ID = 32'h0002_0000
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset,
    sampler_dma_register_bank_if.slave bus,
    output logic [32*MAX_VOICES-1:0] dma_base_addr,
    output logic [32*MAX_VOICES-1:0] dma_length,
    output logic [MAX_VOICES-1:0]    dma_loop,
    output logic [MAX_VOICES-1:0]    dma_start,
    output logic [MAX_VOICES-1:0]    dma_stop,
    input  logic [MAX_VOICES-1:0]    voice_busy,
    input  logic [MAX_VOICES-1:0]    voice_done,
    input  logic [32*MAX_VOICES-1:0] voice_cur_addr,
    output logic                     irq
);

    localparam logic [ADDR_W-1:0] c_addr_pend    = ADDR_W'(MAX_VOICES*4);
    localparam logic [ADDR_W-1:0] c_addr_irq_en  = ADDR_W'(MAX_VOICES*4 + 1);
    localparam logic [ADDR_W-1:0] c_addr_version = ADDR_W'(MAX_VOICES*4 + 2);

    logic [31:0]           r_base_sh [MAX_VOICES];
    logic [31:0]           r_len_sh  [MAX_VOICES];
    logic [31:0]           r_base_cm [MAX_VOICES];
    logic [31:0]           r_len_cm  [MAX_VOICES];
    logic [MAX_VOICES-1:0] r_loop;
    logic [MAX_VOICES-1:0] r_done;
    logic [MAX_VOICES-1:0] r_err;
    logic [MAX_VOICES-1:0] r_irq_en;
    logic [MAX_VOICES-1:0] r_start;
    logic [MAX_VOICES-1:0] r_stop;
    logic                  r_irq;
    logic [31:0]           r_data_out;

    logic [MAX_VOICES-1:0] w_wr_base;
    logic [MAX_VOICES-1:0] w_wr_len;
    logic [MAX_VOICES-1:0] w_ctl_wr;
    logic [MAX_VOICES-1:0] w_stat_wr;
    logic [MAX_VOICES-1:0] w_start_req;
    logic [MAX_VOICES-1:0] w_start_ok;
    logic [MAX_VOICES-1:0] w_start_bad;
    logic [MAX_VOICES-1:0] w_stop_req;
    logic [MAX_VOICES-1:0] w_done_clr;
    logic [MAX_VOICES-1:0] w_err_clr;
    logic                  w_wr_pend;
    logic                  w_wr_irq_en;
    logic [31:0]           w_rd_data;

    // The engine's live fetch address is not exposed through the register map.
    logic w_unused_cur_addr;
    assign w_unused_cur_addr = ^voice_cur_addr;

    function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

    assign w_wr_pend   = bus.data_wren && (bus.reg_addr_wr == c_addr_pend);
    assign w_wr_irq_en = bus.data_wren && (bus.reg_addr_wr == c_addr_irq_en);

    always_comb begin
        w_wr_base   = '0;
        w_wr_len    = '0;
        w_ctl_wr    = '0;
        w_stat_wr   = '0;
        w_start_req = '0;
        w_start_ok  = '0;
        w_start_bad = '0;
        w_stop_req  = '0;
        w_done_clr  = '0;
        w_err_clr   = '0;
        for (int v = 0; v < MAX_VOICES; v++) begin
            w_wr_base[v] = bus.data_wren && (bus.reg_addr_wr == ADDR_W'(4*v));
            w_wr_len[v]  = bus.data_wren && (bus.reg_addr_wr == ADDR_W'(4*v + 1));
            w_ctl_wr[v]  = bus.data_wren && (bus.reg_addr_wr == ADDR_W'(4*v + 2))
                           && bus.byte_enable[0];
            w_stat_wr[v] = bus.data_wren && (bus.reg_addr_wr == ADDR_W'(4*v + 3))
                           && bus.byte_enable[0];
            // STOP in the same word as START suppresses START without flagging an error.
            w_stop_req[v]  = w_ctl_wr[v] && bus.data_in[1];
            w_start_req[v] = w_ctl_wr[v] && bus.data_in[0] && !bus.data_in[1];
            w_start_ok[v]  = w_start_req[v] && !voice_busy[v] && (r_len_sh[v] != 32'd0);
            w_start_bad[v] = w_start_req[v] && !w_start_ok[v];
            w_done_clr[v]  = w_start_ok[v]
                             || (w_stat_wr[v] && bus.data_in[1])
                             || (w_wr_pend && bus.byte_enable[v/8] && bus.data_in[v]);
            w_err_clr[v]   = w_start_ok[v] || (w_stat_wr[v] && bus.data_in[2]);
        end
    end

    always_comb begin
        w_rd_data = 32'hDEAD_BEEF;
        for (int v = 0; v < MAX_VOICES; v++) begin
            if (bus.reg_addr_rd == ADDR_W'(4*v))     w_rd_data = r_base_sh[v];
            if (bus.reg_addr_rd == ADDR_W'(4*v + 1)) w_rd_data = r_len_sh[v];
            if (bus.reg_addr_rd == ADDR_W'(4*v + 2)) w_rd_data = {29'd0, r_loop[v], 2'b00};
            if (bus.reg_addr_rd == ADDR_W'(4*v + 3))
                w_rd_data = {29'd0, r_err[v], r_done[v], voice_busy[v]};
        end
        if (bus.reg_addr_rd == c_addr_pend)    w_rd_data = 32'(r_done);
        if (bus.reg_addr_rd == c_addr_irq_en)  w_rd_data = 32'(r_irq_en);
        if (bus.reg_addr_rd == c_addr_version) w_rd_data = VERSION_ID | 32'(MAX_VOICES);
    end

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            for (int v = 0; v < MAX_VOICES; v++) begin
                r_base_sh[v] <= '0;
                r_len_sh[v]  <= '0;
                r_base_cm[v] <= '0;
                r_len_cm[v]  <= '0;
            end
            r_loop     <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_irq_en   <= '0;
            r_start    <= '0;
            r_stop     <= '0;
            r_irq      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_start    <= w_start_ok;
            r_stop     <= w_stop_req;
            // A completion arriving with a clear keeps the bit set.
            r_done     <= voice_done | (r_done & ~w_done_clr);
            r_err      <= w_start_bad | (r_err & ~w_err_clr);
            r_irq      <= |(r_done & r_irq_en);
            r_data_out <= w_rd_data;
            for (int v = 0; v < MAX_VOICES; v++) begin
                if (w_wr_base[v]) r_base_sh[v] <= merge_be(r_base_sh[v], bus.data_in, bus.byte_enable);
                if (w_wr_len[v])  r_len_sh[v]  <= merge_be(r_len_sh[v], bus.data_in, bus.byte_enable);
                if (w_ctl_wr[v])  r_loop[v]    <= bus.data_in[2];
                if (w_start_ok[v]) begin
                    r_base_cm[v] <= r_base_sh[v];
                    r_len_cm[v]  <= r_len_sh[v];
                end
                if (w_wr_irq_en && bus.byte_enable[v/8]) r_irq_en[v] <= bus.data_in[v];
            end
        end
    end

    generate
        for (genvar gv = 0; gv < MAX_VOICES; gv++) begin : g_out
            assign dma_base_addr[32*gv +: 32] = r_base_cm[gv];
            assign dma_length[32*gv +: 32]    = r_len_cm[gv];
        end
    endgenerate

    assign dma_loop     = r_loop;
    assign dma_start    = r_start;
    assign dma_stop     = r_stop;
    assign irq          = r_irq;
    assign bus.data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_sampler_dma_register_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_sampler_dma_register_bank
// Purpose  : Directed plus randomized checks against a transaction-level model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_sampler_dma_register_bank;

    localparam int NV = 8;
    localparam int AW = 8;
    localparam int G  = NV*4;

    logic                 axi_clk;
    logic                 axi_reset;
    logic [32*NV-1:0]     dma_base_addr;
    logic [32*NV-1:0]     dma_length;
    logic [NV-1:0]        dma_loop;
    logic [NV-1:0]        dma_start;
    logic [NV-1:0]        dma_stop;
    logic [NV-1:0]        voice_busy;
    logic [NV-1:0]        voice_done;
    logic [32*NV-1:0]     voice_cur_addr;
    logic                 irq;

    sampler_dma_register_bank_if #(.ADDR_W(AW)) bus ();

    sampler_dma_register_bank #(.MAX_VOICES(NV), .ADDR_W(AW), .VERSION_ID(32'h0002_0000)) dut (
        .axi_clk        (axi_clk),
        .axi_reset      (axi_reset),
        .bus            (bus),
        .dma_base_addr  (dma_base_addr),
        .dma_length     (dma_length),
        .dma_loop       (dma_loop),
        .dma_start      (dma_start),
        .dma_stop       (dma_stop),
        .voice_busy     (voice_busy),
        .voice_done     (voice_done),
        .voice_cur_addr (voice_cur_addr),
        .irq            (irq)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what software would see through the register map.
    logic [31:0] m_base [NV];
    logic [31:0] m_len  [NV];
    logic [31:0] m_bcm  [NV];
    logic [31:0] m_lcm  [NV];
    logic [NV-1:0] m_loop, m_done, m_err, m_en, exp_start, exp_stop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_wide(input string tag, input logic [32*NV-1:0] obs, input logic [32*NV-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void reset_model();
        for (int v = 0; v < NV; v++) begin
            m_base[v] = '0; m_len[v] = '0; m_bcm[v] = '0; m_lcm[v] = '0;
        end
        m_loop = '0; m_done = '0; m_err = '0; m_en = '0;
        exp_start = '0; exp_stop = '0;
    endfunction

    function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        logic [31:0] tmp;
        int v;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (a < G) begin
            v = a / 4;
            case (a % 4)
                0: m_base[v] = (m_base[v] & ~mask) | (d & mask);
                1: m_len[v]  = (m_len[v] & ~mask) | (d & mask);
                2: if (be[0]) begin
                    m_loop[v] = d[2];
                    if (d[1]) exp_stop[v] = 1'b1;
                    else if (d[0]) begin
                        if (voice_busy[v] || m_len[v] == 0) m_err[v] = 1'b1;
                        else begin
                            exp_start[v] = 1'b1;
                            m_bcm[v] = m_base[v]; m_lcm[v] = m_len[v];
                            m_done[v] = 1'b0; m_err[v] = 1'b0;
                        end
                    end
                end
                default: if (be[0]) begin
                    if (d[1]) m_done[v] = 1'b0;
                    if (d[2]) m_err[v]  = 1'b0;
                end
            endcase
        end else if (a == G) begin
            tmp = d & mask;
            m_done = m_done & ~tmp[NV-1:0];
        end else if (a == G + 1) begin
            tmp = (32'(m_en) & ~mask) | (d & mask);
            m_en = tmp[NV-1:0];
        end
    endfunction

    function automatic logic [31:0] model_read(input int a);
        int v;
        v = a / 4;
        if (a < G) begin
            case (a % 4)
                0: return m_base[v];
                1: return m_len[v];
                2: return {29'd0, m_loop[v], 2'b00};
                default: return {29'd0, m_err[v], m_done[v], voice_busy[v]};
            endcase
        end
        if (a == G)     return 32'(m_done);
        if (a == G + 1) return 32'(m_en);
        if (a == G + 2) return 32'h0002_0000 | 32'(NV);
        return 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: optional write, a read, optional completion pulses; then check everything.
    task automatic step(input logic we, input int wa, input logic [31:0] wd, input logic [3:0] wbe,
                        input int ra, input logic [NV-1:0] vdone);
        logic [31:0]      exp_rd;
        logic             exp_irq;
        logic [32*NV-1:0] eb, el;
        exp_rd  = model_read(ra);
        exp_irq = |(m_done & m_en);
        exp_start = '0;
        exp_stop  = '0;
        bus.data_wren   = we;
        bus.reg_addr_wr = AW'(wa);
        bus.data_in     = wd;
        bus.byte_enable = wbe;
        bus.reg_addr_rd = AW'(ra);
        voice_done      = vdone;
        if (we) model_write(wa, wd, wbe);
        m_done = m_done | vdone;
        @(posedge axi_clk);
        #1;
        bus.data_wren = 1'b0;
        voice_done    = '0;
        for (int v = 0; v < NV; v++) begin
            eb[32*v +: 32] = m_bcm[v];
            el[32*v +: 32] = m_lcm[v];
        end
        check("data_out", bus.data_out, exp_rd);
        check("irq", 32'(irq), 32'(exp_irq));
        check("dma_start", 32'(dma_start), 32'(exp_start));
        check("dma_stop", 32'(dma_stop), 32'(exp_stop));
        check("dma_loop", 32'(dma_loop), 32'(m_loop));
        check_wide("dma_base_addr", dma_base_addr, eb);
        check_wide("dma_length", dma_length, el);
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        step(1'b1, a, d, be, G + 3, '0);
    endtask

    task automatic rd(input int a);
        step(1'b0, 0, 32'd0, 4'h0, a, '0);
    endtask

    initial begin
        axi_reset       = 1'b0;
        bus.data_in     = '0;
        bus.reg_addr_wr = '0;
        bus.reg_addr_rd = '0;
        bus.data_wren   = 1'b0;
        bus.byte_enable = '0;
        voice_busy      = '0;
        voice_done      = '0;
        voice_cur_addr  = {NV{32'hCAFE_0000}};
        reset_model();
        repeat (2) @(posedge axi_clk);
        #1;
        check("reset_data_out", bus.data_out, 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        axi_reset = 1'b1;

        // Reset in the middle of activity.
        voice_busy[0] = 1'b1;
        wr(G + 1, 32'h1, 4'hF);
        step(1'b0, 0, 32'd0, 4'h0, 3, 8'h01);
        rd(3);
        check("status0_busy_done", bus.data_out, 32'h3);
        check("irq_before_reset", 32'(irq), 32'h1);
        axi_reset = 1'b0;
        @(posedge axi_clk);
        #1;
        check("mid_reset_irq", 32'(irq), 32'h0);
        check("mid_reset_data_out", bus.data_out, 32'h0);
        check("mid_reset_start_stop", 32'({dma_start, dma_stop}), 32'h0);
        axi_reset  = 1'b1;
        voice_busy = '0;
        reset_model();
        rd(3);
        check("status0_after_reset", bus.data_out, 32'h0);
        rd(0);
        check("base0_after_reset", bus.data_out, 32'h0);

        // Start voice 1 with a committed base/length.
        wr(4, 32'h1000_0000, 4'hF);
        wr(5, 32'h0000_0400, 4'hF);
        wr(6, 32'h5, 4'hF);
        check("start1_pulse", 32'(dma_start), 32'h2);
        check("base1_commit", dma_base_addr[63:32], 32'h1000_0000);
        check("len1_commit", dma_length[63:32], 32'h400);
        check("loop1", 32'(dma_loop[1]), 32'h1);
        rd(6);
        check("start1_one_cycle", 32'(dma_start), 32'h0);
        check("ctl1_read", bus.data_out, 32'h4);
        step(1'b1, 4, 32'h2000_0000, 4'hF, 4, '0);
        check("read_during_write", bus.data_out, 32'h1000_0000);
        wr(6, 32'h3, 4'hF);
        check("stop_wins", 32'({dma_stop, dma_start}), 32'h0200);

        // Byte-enable write.
        wr(8, 32'hAABB_CCDD, 4'b0101);
        rd(8);
        check("base2_byte_en", bus.data_out, 32'h00BB_00DD);
        check("base2_not_committed", dma_base_addr[95:64], 32'h0);

        // Reject paths.
        voice_busy[3] = 1'b1;
        wr(14, 32'h1, 4'hF);
        check("busy_reject_no_start", 32'(dma_start), 32'h0);
        rd(15);
        check("status3_busy_err", bus.data_out, 32'h5);
        voice_busy[3] = 1'b0;
        wr(15, 32'h4, 4'hF);
        wr(14, 32'h1, 4'hF);
        check("len0_reject_no_start", 32'(dma_start), 32'h0);
        rd(15);
        check("status3_len0_err", bus.data_out, 32'h4);
        voice_busy[3] = 1'b1;
        wr(15, 32'h4, 4'hF);
        rd(15);
        check("status3_w1c", bus.data_out, 32'h1);
        voice_busy[3] = 1'b0;

        // Interrupt path.
        wr(G + 1, 32'h1, 4'hF);
        step(1'b0, 0, 32'd0, 4'h0, G, 8'h01);
        rd(G);
        check("irq_pending_set", bus.data_out, 32'h1);
        check("irq_raised", 32'(irq), 32'h1);
        step(1'b1, G, 32'h1, 4'hF, G, 8'h01);
        rd(G);
        check("set_beats_clear", bus.data_out, 32'h1);
        wr(G, 32'h1, 4'hF);
        rd(G);
        check("irq_pending_cleared", bus.data_out, 32'h0);
        check("irq_dropped", 32'(irq), 32'h0);

        // Global reads.
        rd(G + 2);
        check("version", bus.data_out, 32'h0002_0008);
        rd(G + 3);
        check("unmapped", bus.data_out, 32'hDEAD_BEEF);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            voice_busy = NV'($urandom);
            step(($urandom_range(0, 9) < 7), int'($urandom_range(0, G + 4)), $urandom,
                 4'($urandom), int'($urandom_range(0, G + 4)),
                 NV'($urandom & $urandom & $urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
